// File: rtl/flash_adc_pkg.sv
// Shared constants and helpers for the flash ADC back-end.
// Used by the decoder RTL and by the controller model.
package flash_adc_pkg;

    localparam int N_CMP  = 32;
    localparam int CODE_W = 6;

    // Per-sample status bits produced alongside the output code.
    typedef struct packed {
        logic underflow;
        logic overflow;
        logic bubble;
        logic thermo_err;
    } flags_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/flash_popcount.sv
// Combinational ones-counter turning a corrected thermometer word into a code.
module flash_popcount #(
    parameter int N_CMP  = 32,
    parameter int CODE_W = 6
) (
    input  logic [N_CMP-1:0]  bits_i,
    output logic [CODE_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < N_CMP; i++) begin
            count_o = count_o + CODE_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/flash_thermo_decoder.sv
// Three-stage thermometer-to-binary decoder: capture, bubble correction, encode.
// Also tracks a saturating count of samples that needed correction.
module flash_thermo_decoder #(
    parameter int N_CMP  = flash_adc_pkg::N_CMP,
    parameter int CODE_W = flash_adc_pkg::CODE_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CMP-1:0]  Q,
    input  logic              in_valid,
    output logic [CODE_W-1:0] code,
    output logic              out_valid,
    output logic              underflow,
    output logic              overflow,
    output logic              bubble,
    output logic              thermo_err,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    import flash_adc_pkg::*;

    // Stage 1: capture
    logic [N_CMP-1:0] q_q;
    logic             v1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q  <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                q_q <= Q;
            end
        end
    end

    // Stage 2: majority-of-three correction. The word is padded with a
    // virtual 1 below bit 0 and a virtual 0 above the top comparator.
    logic [N_CMP+1:0] q_ext;
    logic [N_CMP-1:0] c_d;
    logic [N_CMP-1:0] c_q;
    logic             v2_q;
    logic             bub_q;

    assign q_ext = {1'b0, q_q, 1'b1};

    generate
        for (genvar gi = 0; gi < N_CMP; gi++) begin : g_corr
            assign c_d[gi] = maj3(q_ext[gi], q_ext[gi+1], q_ext[gi+2]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q   <= '0;
            v2_q  <= 1'b0;
            bub_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                c_q   <= c_d;
                bub_q <= (c_d != q_q);
            end
        end
    end

    // Stage 3: encode and flag
    logic [CODE_W-1:0] pop_code;
    logic              thermo_err_d;
    flags_t            flags_d;
    flags_t            flags_q;
    logic [CODE_W-1:0] code_q;
    logic              out_valid_q;

    flash_popcount #(
        .N_CMP  (N_CMP),
        .CODE_W (CODE_W)
    ) u_popcount (
        .bits_i  (c_q),
        .count_o (pop_code)
    );

    // A 0 directly below a 1 anywhere means the word is not a thermometer.
    assign thermo_err_d = |(~c_q[N_CMP-2:0] & c_q[N_CMP-1:1]);

    always_comb begin
        flags_d            = '0;
        flags_d.underflow  = (pop_code == '0);
        flags_d.overflow   = (pop_code == CODE_W'(N_CMP));
        flags_d.bubble     = bub_q;
        flags_d.thermo_err = thermo_err_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q      <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                code_q  <= pop_code;
                flags_q <= flags_d;
            end
        end
    end

    // Bubble-event counter: clear has priority over increment, no wrap.
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (v2_q && bub_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign code       = code_q;
    assign out_valid  = out_valid_q;
    assign underflow  = flags_q.underflow;
    assign overflow   = flags_q.overflow;
    assign bubble     = flags_q.bubble;
    assign thermo_err = flags_q.thermo_err;
    assign bubble_cnt = cnt_q;

endmodule
